uart_tx_buffered: RTL and testbench
===================================

UART_TX_BUFFERED -- requirements
Module: uart_tx_buffered

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, SHALL set clk cycles per serial bit (50 MHz / 115200 baud); legal range 2..65535.
REQ-002 Parameter FIFO_DEPTH, default 4, SHALL set transmit buffer entries; power of two, 2..16.
REQ-003 clk  input  1  SHALL be the system clock; all logic rising-edge.
REQ-004 rst  input  1  SHALL be the reset: asynchronous, active-high.
REQ-005 tx_wdata  input  8  SHALL be the byte to transmit, sampled when tx_wr=1.
REQ-006 tx_wr  input  1  SHALL be the one-cycle write strobe from the CSR block.
REQ-007 tbr_valid  output  1  SHALL be 1 when the buffer can accept a byte (not full).
REQ-008 tx_busy  output  1  SHALL be 1 while a frame is on the line or the buffer is non-empty.
REQ-009 txd  output  1  SHALL be the registered serial line, idle high.

Function
REQ-010 Frame SHALL be 8N1: start bit 0, data bits LSB first, one stop bit 1; every bit held exactly CLKS_PER_BIT cycles; frame length 10*CLKS_PER_BIT cycles.
REQ-011 tx_wr with tbr_valid=1 SHALL push tx_wdata into the FIFO at that rising edge.
REQ-012 tx_wr with tbr_valid=0 SHALL be ignored: FIFO contents, pointers and count unchanged, no error flag.
REQ-013 tbr_valid SHALL be computed from the registered count only; a pop in the same cycle does not make a write to a full FIFO succeed.
REQ-014 FSM states SHALL be IDLE, START, DATA, STOP.
REQ-015 IDLE: txd=1; if FIFO non-empty, pop head into shift register, load baud counter, go to START.
REQ-016 START: txd=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
REQ-017 DATA: txd=shift[0]; each CLKS_PER_BIT expiry shifts right and increments bit index; after bit 7 expiry go to STOP.
REQ-018 STOP: txd=1 for CLKS_PER_BIT cycles; at expiry pop and go to START if FIFO non-empty (no idle gap between back-to-back frames), else IDLE.
REQ-019 Latency: byte written at edge N into an empty FIFO with FSM in IDLE SHALL drive txd=0 from edge N+2.
REQ-020 Baud counter SHALL count down from CLKS_PER_BIT-1 to 0; width clog2(CLKS_PER_BIT); expiry at 0 reloads.
REQ-021 FIFO pointers SHALL wrap modulo FIFO_DEPTH; count width clog2(FIFO_DEPTH)+1; simultaneous push and pop SHALL leave count unchanged.
REQ-022 tx_busy SHALL be 0 only when state=IDLE and count=0.

Reset
REQ-023 rst SHALL immediately force txd=1, state=IDLE, FIFO pointers and count=0, baud counter=0, bit index=0, shift register=0.
REQ-024 After reset tbr_valid=1 and tx_busy=0; a frame in progress at reset SHALL be abandoned and buffered bytes discarded.
REQ-025 Reset deassertion is synchronous to clk upstream; no internal resynchroniser.

Structure
REQ-026 FSM state encoding, frame constants (DATA_BITS=8, START_LVL=0, STOP_LVL=1) SHALL live in shared package uart_pkg, reused by the receiver.
REQ-027 The buffer SHALL be sub-module uart_tx_fifo (synchronous FIFO, registered count, full/empty flags); uart_tx_buffered holds the FSM, baud counter and shifter.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-028 Write 0x55 at edge N, idle -> txd=0 from N+2 for 4 cycles, then 1,0,1,0,1,0,1,0 at 4 cycles each, stop 1; tx_busy low at N+42.
REQ-029 Write 0xA3, 0x0F on consecutive cycles -> two frames, second start bit immediately after first stop bit (80 cycles total, no gap).
REQ-030 Six writes on consecutive cycles while idle -> first five accepted (one popped, four buffered), tbr_valid=0 on sixth, sixth byte never transmitted.
REQ-031 FIFO full, tx_wr asserted on the pop cycle -> write ignored; next cycle tbr_valid=1 and a write succeeds.
REQ-032 Assert rst during DATA bit 3 of 0xFF with two bytes buffered -> txd=1 same cycle, tx_busy=0, tbr_valid=1 after release, no further frames.
REQ-033 Random byte stream with a monitor decoding txd at mid-bit -> decoded sequence equals accepted sequence.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and 8N1 frame constants,
// common to the transmitter and receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } uart_state_e;

  localparam int unsigned DATA_BITS = 8;
  localparam logic        START_LVL = 1'b0;
  localparam logic        STOP_LVL  = 1'b1;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous transmit FIFO with a registered occupancy count.
// A write to a full FIFO and a read from an empty FIFO are dropped.
module uart_tx_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic [Width-1:0] wdata,
  input  logic             rd,
  output logic [Width-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             push, pop;

  // Flags come from the registered count only, so a same-cycle pop never
  // opens room for a write.
  assign full  = (cnt_q == CntW'(Depth));
  assign empty = (cnt_q == '0);
  assign push  = wr & ~full;
  assign pop   = rd & ~empty;
  assign rdata = mem_q[rptr_q];

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= wdata;
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: FIFO front end, frame FSM, baud counter
// and shift register driving a registered serial line.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_wdata,
  input  logic       tx_wr,
  output logic       tbr_valid,
  output logic       tx_busy,
  output logic       txd
);

  localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);
  localparam int unsigned BitW  = $clog2(DATA_BITS);
  localparam logic [BaudW-1:0] BaudMax = BaudW'(CLKS_PER_BIT - 1);
  localparam logic [BitW-1:0]  LastBit = BitW'(DATA_BITS - 1);

  uart_state_e          state_q, state_d;
  logic [BaudW-1:0]     baud_q, baud_d;
  logic [BitW-1:0]      bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 txd_q, line;
  logic                 pop;
  logic [DATA_BITS-1:0] fifo_rdata;
  logic                 fifo_full, fifo_empty;
  logic                 baud_done;

  uart_tx_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (DATA_BITS)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .wr    (tx_wr),
    .wdata (tx_wdata),
    .rd    (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign baud_done = (baud_q == '0);
  assign tbr_valid = ~fifo_full;
  assign tx_busy   = (state_q != StIdle) || !fifo_empty;
  assign txd       = txd_q;

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    line    = STOP_LVL;
    unique case (state_q)
      StIdle: begin
        line = STOP_LVL;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_rdata;
          baud_d  = BaudMax;
          state_d = StStart;
        end
      end
      StStart: begin
        line = START_LVL;
        if (baud_done) begin
          baud_d  = BaudMax;
          bit_d   = '0;
          state_d = StData;
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      StData: begin
        line = shift_q[0];
        if (baud_done) begin
          baud_d  = BaudMax;
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 1'b1;
          if (bit_q == LastBit) state_d = StStop;
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      StStop: begin
        line = STOP_LVL;
        if (baud_done) begin
          // Chain straight into the next start bit when more data is queued.
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_rdata;
            baud_d  = BaudMax;
            state_d = StStart;
          end else begin
            state_d = StIdle;
          end
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // txd follows the current state's level, one cycle behind the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      txd_q   <= line;
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Scoreboard bench for uart_tx_buffered: a frame-level model predicts buffer
// occupancy and accepted bytes; a monitor decodes txd at mid-bit.
module tb_uart_tx_buffered;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_wdata = 8'h00;
  logic       tx_wr = 1'b0;
  logic       tbr_valid, tx_busy, txd;

  int checks   = 0;
  int failures = 0;

  // Frame-level model: edge counter, buffered-byte count, edge at which
  // the transmitter can next take a byte.
  int         cyc     = 0;
  int         m_count = 0;
  int         m_free  = 0;
  logic       m_pop;
  logic [7:0] exp_q[$];

  uart_tx_buffered #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tx_wdata  (tx_wdata),
    .tx_wr     (tx_wr),
    .tbr_valid (tbr_valid),
    .tx_busy   (tx_busy),
    .txd       (txd)
  );

  always #5 clk = ~clk;

  assign m_pop = (m_count > 0) && ((cyc + 1) >= m_free);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      m_count <= 0;
      m_free  <= 0;
      exp_q.delete();
    end else begin
      if (tx_wr && m_count < DEPTH) exp_q.push_back(tx_wdata);
      if (m_pop) m_free <= cyc + 1 + FRAME;
      m_count <= m_count + int'(tx_wr && m_count < DEPTH) - int'(m_pop);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Flag outputs against the model every cycle.
  always @(negedge clk) begin
    if (!rst) begin
      check("tbr_valid_model", tbr_valid, (m_count < DEPTH));
      check("tx_busy_model", tx_busy, (m_count > 0 || cyc < m_free));
    end
  end

  task automatic wait_neg(input int n, inout bit ab);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (rst) ab = 1'b1;
    end
  endtask

  task automatic decode_frame();
    logic [7:0] data;
    logic       start_lvl, stop_lvl;
    logic [7:0] exp;
    bit         ab;
    ab = 1'b0;
    wait_neg(CPB / 2, ab);
    start_lvl = txd;
    for (int i = 0; i < 8; i++) begin
      wait_neg(CPB, ab);
      data[i] = txd;
    end
    wait_neg(CPB, ab);
    stop_lvl = txd;
    if (ab) return;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_frame: got %02h expected no frame", data);
    end else begin
      exp = exp_q.pop_front();
      check("frame_data", data, exp);
      check("frame_framing", {start_lvl, stop_lvl}, 2'b01);
    end
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!rst && txd === 1'b0) decode_frame();
    end
  end

  task automatic drive(input logic wr, input logic [7:0] d);
    tx_wr    = wr;
    tx_wdata = d;
    @(negedge clk);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (!(m_count == 0 && cyc >= m_free) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_in_budget", (n < budget), 1'b1);
    repeat (CPB) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
  endtask

  function automatic logic wave_level(input int k, input logic [7:0] b0, input logic [7:0] b1,
                                      input int nf);
    int t, f, b;
    logic [7:0] d;
    if (k < 2) return 1'b1;
    t = k - 2;
    f = t / FRAME;
    if (f >= nf) return 1'b1;
    b = (t % FRAME) / CPB;
    d = (f == 0) ? b0 : b1;
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    return 1'b1;
  endfunction

  // Cycle-exact txd check for frames whose first byte was written at edge n0.
  task automatic check_wave(input int n0, input logic [7:0] b0, input logic [7:0] b1,
                            input int nf);
    int last;
    last = n0 + 2 + FRAME * nf;
    while (cyc <= last) begin
      check("txd_wave", txd, wave_level(cyc - n0, b0, b1, nf));
      if (cyc == last) check("busy_low_after_frames", tx_busy, 1'b0);
      @(negedge clk);
    end
  endtask

  task automatic wait_cyc(input int target);
    int g;
    g = 0;
    while (cyc < target && g < 1000) begin
      @(negedge clk);
      g++;
    end
    check("reach_cycle", (cyc == target), 1'b1);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int         n0;
    logic       exp6 [6];
    logic [7:0] d;
    exp6 = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_txd", txd, 1'b1);
    check("reset_tbr_valid", tbr_valid, 1'b1);
    check("reset_tx_busy", tx_busy, 1'b0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single byte, exact waveform and latency
    n0 = cyc + 1;
    drive(1'b1, 8'h55);
    drive(1'b0, 8'h00);
    check_wave(n0, 8'h55, 8'h00, 1);
    wait_idle(200);

    // Back-to-back frames with no idle gap
    n0 = cyc + 1;
    drive(1'b1, 8'hA3);
    drive(1'b1, 8'h0F);
    drive(1'b0, 8'h00);
    check_wave(n0, 8'hA3, 8'h0F, 2);
    wait_idle(200);

    // Six writes while idle: the sixth hits a full buffer
    for (int i = 0; i < 6; i++) begin
      check("tbr_valid_seq", tbr_valid, exp6[i]);
      drive(1'b1, 8'h30 + 8'(i));
    end
    drive(1'b0, 8'h00);

    // Write on the pop cycle is dropped; the next one is taken
    wait_cyc(m_free - 1);
    check("full_on_pop_cycle", tbr_valid, 1'b0);
    drive(1'b1, 8'hC1);
    check("room_after_pop", tbr_valid, 1'b1);
    drive(1'b1, 8'h3C);
    drive(1'b0, 8'h00);
    wait_idle(400);

    // Random byte stream
    for (int i = 0; i < 300; i++) begin
      d = 8'($urandom);
      drive(($urandom_range(0, 2) == 0), d);
    end
    drive(1'b0, 8'h00);
    wait_idle(600);

    // Reset during DATA bit 3 of 0xFF with two bytes buffered
    n0 = cyc + 1;
    drive(1'b1, 8'hFF);
    drive(1'b1, 8'h11);
    drive(1'b1, 8'h22);
    drive(1'b0, 8'h00);
    wait_cyc(n0 + 19);
    check("buffered_before_reset", m_count, 2);
    rst = 1'b1;
    #1;
    check("rst_txd_immediate", txd, 1'b1);
    check("rst_busy_immediate", tx_busy, 1'b0);
    check("rst_tbr_valid", tbr_valid, 1'b1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("idle_after_reset", {txd, tx_busy, tbr_valid}, 3'b101);
    end
    check("no_pending_after_reset", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
